keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Sequencing controller for one 4x3 hangman keypad; host and player sides each get their own instance. It drives the column strobes, samples and debounces the row returns, and decodes phone-style multi-tap letters. It then issues single-cycle letter, word-submit and error strobes to the game logic in place of raw row vectors.

## Interface
- SCAN_CYCLES, default 100: clock cycles each column strobe is held during scanning.
- DEBOUNCE_CYCLES, default 20: consecutive identical synchronized samples required to accept a press or a release.
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- row  input  4  keypad row returns: bit3=R0, bit2=R1, bit1=R2, bit0=R3. Asynchronous to clk.
- col  output  3  one-hot column strobe: bit2=C0, bit1=C1, bit0=C2.
- preview  output  8  ASCII of the tentative multi-tap letter; 8'h00 when none is pending.
- letter  output  8  ASCII of the committed letter; valid only while letter_valid is high.
- letter_valid  output  1  one-cycle strobe when a letter is committed.
- word_submit  output  1  one-cycle strobe when the submit-word key is accepted.
- error  output  1  one-cycle strobe on an illegal action.
- busy  output  1  high in any state other than SCAN.

## Operation
- Row input passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- Key map, by row then column:
  - R0: C0 none, C1 ABC, C2 DEF.
  - R1: C0 GHI, C1 JKL, C2 MNO.
  - R2: C0 PQRS, C1 TUV, C2 WXYZ.
  - R3: C0 SUBMIT_LETTER, C1 CLEAR, C2 SUBMIT_WORD.
- FSM states:
  - SCAN: rotate col C0→C1→C2→C0 every SCAN_CYCLES. On the last dwell cycle, if `rs` is nonzero, latch col and `rs`, then go to DEBOUNCE. Otherwise advance to the next column.
  - DEBOUNCE: col is frozen. `rs` must equal the latched row for DEBOUNCE_CYCLES consecutive cycles; then go to ACT. Any mismatch returns to SCAN at the same column.
  - ACT: a single cycle that performs the key action, then goes to HELD.
  - HELD: wait until `rs` is zero, then go to RELEASE.
  - RELEASE: `rs` must be zero for DEBOUNCE_CYCLES cycles; then go to SCAN at the next column. Any nonzero sample returns to HELD.
- Key actions in ACT:
  - Letter key, same key as the pending one: tap index = (index+1) mod group size, where group size is 3, or 4 for PQRS and WXYZ.
  - Letter key, different from the pending one (or none pending): tap index = 0; this key becomes the pending key.
  - SUBMIT_LETTER with a letter pending: letter=preview and letter_valid=1. The pending key is then cleared and preview becomes 8'h00.
  - SUBMIT_LETTER with nothing pending: error=1.
  - CLEAR: discard the pending key; preview becomes 8'h00. No strobe.
  - SUBMIT_WORD with a letter pending: error=1; the pending letter is kept.
  - SUBMIT_WORD with nothing pending: word_submit=1.
  - R0C0: no action.
- A latched row with more than one bit set is multi-key. The FSM still enters ACT, which only asserts error, then goes through HELD/RELEASE normally.
- A pending letter has no timeout; it persists until submit, clear or reset.

## Timing
- Reset values: col=3'b100 (C0), preview=8'h00, letter=8'h00, and letter_valid, word_submit, error and busy all 0. The FSM resets to SCAN with the dwell counter at 0 and no key pending. The synchronizer flops also reset to 0.
- Press latency: 2 synchronizer cycles, plus up to 3·SCAN_CYCLES to reach the key's column, plus DEBOUNCE_CYCLES, plus 1. All strobes and preview updates are registered and appear in the cycle after ACT.
- Each strobe lasts exactly one cycle. At most one of letter_valid, word_submit and error is high in any cycle.
- letter holds its value until the next commit.
- A key held indefinitely produces exactly one action. Rescanning resumes only after the release debounce completes.
- If rst is asserted mid-debounce or mid-hold, all state clears immediately. A key still held when rst is released is detected fresh from SCAN.
- The dwell and debounce counters are sized $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)+1) bits. The tap index is 2 bits.

## Structure
- keypad_pkg holds:
  - the state enum {SCAN, DEBOUNCE, ACT, HELD, RELEASE};
  - a key-code enum for the 12 keys;
  - the letter group base ASCII values and group sizes;
  - the function that maps (row, col) to a key code.
- One sub-module, keypad_multitap: pending key and tap index registers, plus the ASCII preview computation. It takes a key-code and an act pulse as inputs.

## Test plan
- Reset: rst pulse → col=3'b100, all strobes 0, preview=8'h00, busy=0. col rotates C0→C1→C2 every SCAN_CYCLES.
- Single tap A, then submit: row=4'b1000 held on C1, then released, then row=4'b0001 on C0 → preview 8'h41, then letter=8'h41 with a one-cycle letter_valid; preview returns to 8'h00.
- Multi-tap: JKL pressed three times, with a full release between presses → preview 8'h4A, then 8'h4B, then 8'h4C. PQRS pressed five times → preview wraps back to 8'h50.
- Bounce: row toggled every 5 cycles for 50 cycles (DEBOUNCE_CYCLES=20) → no action and no strobe. A subsequent clean press is accepted once.
- Errors: SUBMIT_LETTER with nothing pending → error pulse. SUBMIT_WORD with 'E' pending → error pulse and preview stays 8'h45. SUBMIT_WORD after a commit → word_submit pulse.
- Reset mid-DEBOUNCE, with the key held through and after rst → the key is re-detected and produces exactly one action.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and key-map helpers for the keypad scan controller
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_ACT,
    ST_HELD,
    ST_RELEASE
  } state_e;

  // Enum order equals row*3+col, so decode is a single arithmetic step.
  typedef enum logic [3:0] {
    K_NONE,
    K_ABC,
    K_DEF,
    K_GHI,
    K_JKL,
    K_MNO,
    K_PQRS,
    K_TUV,
    K_WXYZ,
    K_SUB_LETTER,
    K_CLEAR,
    K_SUB_WORD
  } key_e;

  localparam logic [7:0] BASE_ABC  = 8'h41;
  localparam logic [7:0] BASE_DEF  = 8'h44;
  localparam logic [7:0] BASE_GHI  = 8'h47;
  localparam logic [7:0] BASE_JKL  = 8'h4A;
  localparam logic [7:0] BASE_MNO  = 8'h4D;
  localparam logic [7:0] BASE_PQRS = 8'h50;
  localparam logic [7:0] BASE_TUV  = 8'h54;
  localparam logic [7:0] BASE_WXYZ = 8'h57;

  localparam logic [2:0] GROUP_SIZE_3 = 3'd3;
  localparam logic [2:0] GROUP_SIZE_4 = 3'd4;

  function automatic logic is_letter(key_e k);
    return (k >= K_ABC) && (k <= K_WXYZ);
  endfunction

  function automatic logic [7:0] group_base(key_e k);
    logic [7:0] b;
    case (k)
      K_ABC:   b = BASE_ABC;
      K_DEF:   b = BASE_DEF;
      K_GHI:   b = BASE_GHI;
      K_JKL:   b = BASE_JKL;
      K_MNO:   b = BASE_MNO;
      K_PQRS:  b = BASE_PQRS;
      K_TUV:   b = BASE_TUV;
      K_WXYZ:  b = BASE_WXYZ;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] group_size(key_e k);
    return ((k == K_PQRS) || (k == K_WXYZ)) ? GROUP_SIZE_4 : GROUP_SIZE_3;
  endfunction

  // Row and column arrive one-hot with R0/C0 in the MSB position.
  function automatic key_e decode_key(logic [3:0] row, logic [2:0] col);
    logic [3:0] r;
    logic [3:0] c;
    r = row[3] ? 4'd0 : row[2] ? 4'd1 : row[1] ? 4'd2 : 4'd3;
    c = col[2] ? 4'd0 : col[1] ? 4'd1 : 4'd2;
    return key_e'(r * 4'd3 + c);
  endfunction

endpackage

// File: rtl/keypad_multitap.sv
// rtl/keypad_multitap.sv - pending multi-tap key, tap index and ASCII preview
module keypad_multitap
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       act_i,
  input  key_e       key_i,
  output logic [7:0] preview_o,
  output logic       pending_o
);

  key_e       pend_key_q, pend_key_d;
  logic       pend_q, pend_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] idx_next;

  assign idx_next = {1'b0, idx_q} + 3'd1;

  always_comb begin
    pend_key_d = pend_key_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    if (act_i) begin
      if (is_letter(key_i)) begin
        if (pend_q && (key_i == pend_key_q)) begin
          idx_d = (idx_next == group_size(key_i)) ? 2'd0 : idx_next[1:0];
        end else begin
          pend_key_d = key_i;
          pend_d     = 1'b1;
          idx_d      = 2'd0;
        end
      end else if ((key_i == K_SUB_LETTER) || (key_i == K_CLEAR)) begin
        // A failed submit has nothing to clear, so clearing unconditionally is safe.
        pend_d = 1'b0;
        idx_d  = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_key_q <= K_NONE;
      pend_q     <= 1'b0;
      idx_q      <= 2'd0;
    end else begin
      pend_key_q <= pend_key_d;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
    end
  end

  assign preview_o = pend_q ? (group_base(pend_key_q) + {6'd0, idx_q}) : 8'h00;
  assign pending_o = pend_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - column scan, row debounce and key-action sequencing
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 100,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [7:0] preview,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       word_submit,
  output logic       error,
  output logic       busy
);

  localparam int MAX_CYC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync_q, rs_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    col_q, col_d;
  logic [3:0]    row_lat_q, row_lat_d;
  logic [7:0]    letter_q, letter_d;
  logic          lv_q, lv_d;
  logic          ws_q, ws_d;
  logic          err_q, err_d;
  logic          act_tap;
  logic          multi_key;
  logic          pending;
  key_e          act_key;
  logic [7:0]    preview_w;

  assign multi_key = (row_lat_q & (row_lat_q - 4'd1)) != 4'd0;
  assign act_key   = decode_key(row_lat_q, col_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    row_lat_d = row_lat_q;
    letter_d  = letter_q;
    lv_d      = 1'b0;
    ws_d      = 1'b0;
    err_d     = 1'b0;
    act_tap   = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (rs_q != 4'd0) begin
            row_lat_d = rs_q;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = {col_q[0], col_q[2:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (rs_q != row_lat_q) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACT: begin
        state_d = ST_HELD;
        cnt_d   = '0;
        if (multi_key) begin
          err_d = 1'b1;
        end else begin
          act_tap = 1'b1;
          case (act_key)
            K_SUB_LETTER: begin
              if (pending) begin
                letter_d = preview_w;
                lv_d     = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            K_SUB_WORD: begin
              if (pending) err_d = 1'b1;
              else         ws_d  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_HELD: begin
        if (rs_q == 4'd0) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (rs_q != 4'd0) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          col_d   = {col_q[0], col_q[2:1]};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 4'd0;
      rs_q      <= 4'd0;
      state_q   <= ST_SCAN;
      cnt_q     <= '0;
      col_q     <= 3'b100;
      row_lat_q <= 4'd0;
      letter_q  <= 8'h00;
      lv_q      <= 1'b0;
      ws_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= row;
      rs_q      <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_lat_q <= row_lat_d;
      letter_q  <= letter_d;
      lv_q      <= lv_d;
      ws_q      <= ws_d;
      err_q     <= err_d;
    end
  end

  keypad_multitap u_multitap (
    .clk       (clk),
    .rst       (rst),
    .act_i     (act_tap),
    .key_i     (act_key),
    .preview_o (preview_w),
    .pending_o (pending)
  );

  assign col          = col_q;
  assign preview      = preview_w;
  assign letter       = letter_q;
  assign letter_valid = lv_q;
  assign word_submit  = ws_q;
  assign error        = err_q;
  assign busy         = (state_q != ST_SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed bench for keypad_scan_ctrl with a simple keypad model
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [2:0] col;
  logic [7:0] preview, letter;
  logic       letter_valid, word_submit, error, busy;

  logic       pressed  = 1'b0;
  logic [3:0] key_rows = 4'd0;
  logic [1:0] key_col  = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int lv_cnt = 0, ws_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  logic [7:0] last_letter = 8'h00;

  always #5 clk = ~clk;

  // Rows only return when the key's column is being strobed.
  assign row = (pressed && col[2'd2 - key_col]) ? key_rows : 4'd0;

  keypad_scan_ctrl #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .row          (row),
    .col          (col),
    .preview      (preview),
    .letter       (letter),
    .letter_valid (letter_valid),
    .word_submit  (word_submit),
    .error        (error),
    .busy         (busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (letter_valid) begin
        lv_cnt++;
        last_letter = letter;
      end
      if (word_submit) ws_cnt++;
      if (error) err_cnt++;
      if ((32'(letter_valid) + 32'(word_submit) + 32'(error)) > 1) overlap_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] rows, input logic [1:0] c, input int hold);
    int t;
    key_rows = rows;
    key_col  = c;
    pressed  = 1'b1;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("press_detect", 32'(busy), 32'd1);
    repeat (hold) @(negedge clk);
    pressed = 1'b0;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("release_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col), 32'b100);
    chk("rst_preview", 32'(preview), 32'h00);
    chk("rst_letter", 32'(letter), 32'h00);
    chk("rst_strobes", {29'd0, letter_valid, word_submit, error}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rot_c1", 32'(col), 32'b010);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rot_c2", 32'(col), 32'b001);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rot_c0", 32'(col), 32'b100);

    press(4'b1000, 2'd1, 60);
    chk("tap_A", 32'(preview), 32'h41);
    chk("tap_A_no_commit", 32'(lv_cnt), 32'd0);
    press(4'b0001, 2'd0, 60);
    chk("commit_count", 32'(lv_cnt), 32'd1);
    chk("commit_letter", 32'(last_letter), 32'h41);
    chk("letter_hold", 32'(letter), 32'h41);
    chk("commit_preview", 32'(preview), 32'h00);

    press(4'b0100, 2'd1, 60);
    chk("jkl_1", 32'(preview), 32'h4A);
    press(4'b0100, 2'd1, 60);
    chk("jkl_2", 32'(preview), 32'h4B);
    press(4'b0100, 2'd1, 200);
    chk("jkl_3_long_hold", 32'(preview), 32'h4C);
    press(4'b0001, 2'd1, 60);
    chk("clear_preview", 32'(preview), 32'h00);
    chk("clear_no_strobe", 32'(lv_cnt + ws_cnt + err_cnt), 32'd1);

    press(4'b0010, 2'd0, 60);
    chk("pqrs_1", 32'(preview), 32'h50);
    press(4'b0010, 2'd0, 60);
    press(4'b0010, 2'd0, 60);
    press(4'b0010, 2'd0, 60);
    chk("pqrs_4", 32'(preview), 32'h53);
    press(4'b0010, 2'd0, 60);
    chk("pqrs_wrap", 32'(preview), 32'h50);
    press(4'b0001, 2'd1, 60);

    key_rows = 4'b1000;
    key_col  = 2'd1;
    for (int i = 0; i < 10; i++) begin
      pressed = ~pressed;
      repeat (5) @(negedge clk);
    end
    pressed = 1'b0;
    repeat (5) @(negedge clk);
    wait_idle();
    chk("bounce_preview", 32'(preview), 32'h00);
    chk("bounce_no_strobe", 32'(lv_cnt + ws_cnt + err_cnt), 32'd1);
    press(4'b1000, 2'd1, 60);
    chk("clean_after_bounce", 32'(preview), 32'h41);
    press(4'b0001, 2'd1, 60);

    press(4'b0001, 2'd0, 60);
    chk("sub_letter_empty_err", 32'(err_cnt), 32'd1);
    press(4'b1000, 2'd2, 60);
    press(4'b1000, 2'd2, 60);
    chk("tap_E", 32'(preview), 32'h45);
    press(4'b0001, 2'd2, 60);
    chk("sub_word_pending_err", 32'(err_cnt), 32'd2);
    chk("sub_word_keeps_E", 32'(preview), 32'h45);
    chk("sub_word_pending_no_ws", 32'(ws_cnt), 32'd0);
    press(4'b0001, 2'd0, 60);
    chk("commit_E", 32'(last_letter), 32'h45);
    press(4'b0001, 2'd2, 60);
    chk("word_submit", 32'(ws_cnt), 32'd1);
    chk("word_submit_no_err", 32'(err_cnt), 32'd2);

    press(4'b1100, 2'd1, 60);
    chk("multi_key_err", 32'(err_cnt), 32'd3);
    chk("multi_key_preview", 32'(preview), 32'h00);

    press(4'b1000, 2'd2, 60);
    chk("pre_rst_D", 32'(preview), 32'h44);
    key_rows = 4'b0100;
    key_col  = 2'd0;
    pressed  = 1'b1;
    t = 0;
    while (!busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_db_detect", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_col", 32'(col), 32'b100);
    chk("mid_rst_preview", 32'(preview), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    pressed = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("redetect_G", 32'(preview), 32'h47);
    chk("redetect_no_err", 32'(err_cnt), 32'd3);

    chk("strobe_overlap", 32'(overlap_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
